// File: rtl/tdm_demux41.sv
// tdm_demux41: receive side of a 4-slot TDM link, frame-locked demultiplexer.
// Define TDM_PARITY_EN for a 5-slot frame with a trailing even-parity slot.
module tdm_demux41 #(
   parameter int WIDTH = 1
) (
   input  logic             i_CLK,
   input  logic             i_RST_N,
   input  logic [WIDTH-1:0] i_DATA,
   input  logic             i_EN,
   input  logic             i_SYNC,
   output logic [WIDTH-1:0] o_A,
   output logic [WIDTH-1:0] o_B,
   output logic [WIDTH-1:0] o_C,
   output logic [WIDTH-1:0] o_D,
   output logic             o_VALID,
   output logic             o_LOCK,
   output logic [2:0]       o_SLOT,
   output logic             o_SYNC_ERR,
   output logic             o_PAR_ERR
);

   typedef enum logic {HUNT, LOCKED} state_t;

`ifdef TDM_PARITY_EN
   localparam logic [2:0] LAST = 3'd4;
`else
   localparam logic [2:0] LAST = 3'd3;
`endif

   state_t           state_q, state_d;
   logic [2:0]       slot_q, slot_d;
   logic [WIDTH-1:0] shd_q [4];
   logic [WIDTH-1:0] shd_d [4];
   logic [WIDTH-1:0] a_d, b_d, c_d, d_d;
   logic             valid_d, serr_d, perr_d;

   always_comb begin
      state_d = state_q;
      slot_d  = slot_q;
      shd_d   = shd_q;
      a_d     = o_A;
      b_d     = o_B;
      c_d     = o_C;
      d_d     = o_D;
      valid_d = 1'b0;
      serr_d  = 1'b0;
      perr_d  = 1'b0;
      if (i_EN) begin
         unique case (state_q)
            HUNT: begin
               if (i_SYNC) begin
                  shd_d[0] = i_DATA;
                  slot_d   = 3'd1;
                  state_d  = LOCKED;
               end
            end
            LOCKED: begin
               // sync wins over every slot position: early sync restarts
               priority case (1'b1)
                  i_SYNC: begin
                     serr_d   = (slot_q != 3'd0);
                     shd_d[0] = i_DATA;
                     slot_d   = 3'd1;
                  end
                  (slot_q == 3'd0): begin
                     serr_d  = 1'b1;
                     state_d = HUNT;
                     slot_d  = 3'd0;
                  end
                  (slot_q == LAST): begin
                     slot_d = 3'd0;
`ifdef TDM_PARITY_EN
                     if (i_DATA == (shd_q[0] ^ shd_q[1] ^
                                    shd_q[2] ^ shd_q[3])) begin
                        a_d     = shd_q[0];
                        b_d     = shd_q[1];
                        c_d     = shd_q[2];
                        d_d     = shd_q[3];
                        valid_d = 1'b1;
                     end else begin
                        perr_d = 1'b1;
                     end
`else
                     a_d     = shd_q[0];
                     b_d     = shd_q[1];
                     c_d     = shd_q[2];
                     d_d     = i_DATA;
                     valid_d = 1'b1;
`endif
                  end
                  default: begin
                     shd_d[slot_q[1:0]] = i_DATA;
                     slot_d = slot_q + 3'd1;
                  end
               endcase
            end
            default: state_d = HUNT;
         endcase
      end
   end

   always_ff @(posedge i_CLK or negedge i_RST_N) begin
      if (!i_RST_N) begin
         state_q    <= HUNT;
         slot_q     <= 3'd0;
         shd_q      <= '{default: '0};
         o_A        <= '0;
         o_B        <= '0;
         o_C        <= '0;
         o_D        <= '0;
         o_VALID    <= 1'b0;
         o_SYNC_ERR <= 1'b0;
      end else begin
         state_q    <= state_d;
         slot_q     <= slot_d;
         shd_q      <= shd_d;
         o_A        <= a_d;
         o_B        <= b_d;
         o_C        <= c_d;
         o_D        <= d_d;
         o_VALID    <= valid_d;
         o_SYNC_ERR <= serr_d;
      end
   end

`ifdef TDM_PARITY_EN
   always_ff @(posedge i_CLK or negedge i_RST_N) begin
      if (!i_RST_N) o_PAR_ERR <= 1'b0;
      else          o_PAR_ERR <= perr_d;
   end
`else
   assign o_PAR_ERR = 1'b0;
   logic unused_perr;
   assign unused_perr = perr_d;
`endif

   assign o_LOCK = (state_q == LOCKED);
   assign o_SLOT = slot_q;

endmodule
